keypad_scan_ctrl: RTL and testbench

Sequencing controller for the 4-row × 3-column ATM keypad matrix. On a `start` request from the processor it drives the rows active-low one at a time and samples the active-low columns. It debounces a detected press and reports the row, column and key code through a `dataReady`/`ack` handshake. It then waits for key release before it re-arms. It sits between the keypad pins and the processor's memory-mapped I/O registers.

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/keypad_col_sync.sv | 27 ++
 rtl/keypad_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x3 keypad scan controller.
//   state_t     - controller states
//   col_hit_t   - result of the column priority encode (hit flag + index)
//   col_encode  - lowest-index active-low column wins
//   row_drive   - one-hot-low row drive pattern for a row index
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 3;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DEBOUNCE,
        REPORT,
        RELEASE
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } col_hit_t;

    // Walk from the highest column down so the lowest active column is the
    // last assignment and therefore wins.
    function automatic col_hit_t col_encode(input logic [NUM_COLS-1:0] scol);
        col_hit_t res;
        res.hit = 1'b0;
        res.idx = '0;
        for (int unsigned i = NUM_COLS; i > 0; i--) begin
            if (!scol[i-1]) begin
                res.hit = 1'b1;
                res.idx = 2'(i - 1);
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_ROWS-1:0] row_drive(input logic [1:0] r);
        return ~(NUM_ROWS'(1) << r);
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// keypad_col_sync: 2-flop synchronizer for the asynchronous keypad columns.
//   clock      - system clock
//   reset_n    - asynchronous active-low reset (flops reset to all-ones = idle)
//   async_cols - raw active-low column pins
//   sync_cols  - synchronized columns, two clocks late
module keypad_col_sync
    import keypad_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_COLS-1:0] async_cols,
    output logic [NUM_COLS-1:0] sync_cols
);

    logic [NUM_COLS-1:0] meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta      <= '1;
            sync_cols <= '1;
        end else begin
            meta      <= async_cols;
            sync_cols <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: scan / debounce / report / release sequencer for a
// 4-row x 3-column keypad.
//   clock, reset_n - system clock, asynchronous active-low reset
//   start          - arm request (honoured in IDLE only)
//   ack            - processor consumed the report (honoured in REPORT only)
//   cols           - active-low column pins (asynchronous)
//   rows           - active-low row drive, one-hot-low while busy
//   foundRow/Col   - last reported row/column index, zero-extended
//   keyCode        - last reported row*3+col
//   dataReady      - report valid
//   busy           - high in every state but IDLE
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                ack,
    input  logic [NUM_COLS-1:0] cols,
    output logic [NUM_ROWS-1:0] rows,
    output logic [31:0]         foundRow,
    output logic [31:0]         foundCol,
    output logic [3:0]          keyCode,
    output logic                dataReady,
    output logic                busy
);

    localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [1:0]          row;
    logic [1:0]          col;
    logic [NUM_COLS-1:0] scol;
    logic [1:0]          next_row;
    col_hit_t            hit;

    keypad_col_sync u_sync (
        .clock      (clock),
        .reset_n    (reset_n),
        .async_cols (cols),
        .sync_cols  (scol)
    );

    assign hit      = col_encode(scol);
    assign next_row = (row == 2'(NUM_ROWS - 1)) ? 2'd0 : row + 2'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            row       <= '0;
            col       <= '0;
            rows      <= '1;
            foundRow  <= '0;
            foundCol  <= '0;
            keyCode   <= '0;
            dataReady <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    rows  <= '1;
                    if (start) begin
                        state <= SCAN;
                        row   <= '0;
                        rows  <= row_drive(2'd0);
                        busy  <= 1'b1;
                    end
                end

                SCAN: begin
                    if (count == SETTLE_LAST) begin
                        count <= '0;
                        if (hit.hit) begin
                            col   <= hit.idx;
                            state <= DEBOUNCE;
                        end else begin
                            row  <= next_row;
                            rows <= row_drive(next_row);
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                DEBOUNCE: begin
                    if (hit.hit && hit.idx == col) begin
                        if (count == DEBOUNCE_LAST) begin
                            count <= '0;
                            state <= REPORT;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else begin
                        // Re-settle on the same row rather than advancing.
                        count <= '0;
                        state <= SCAN;
                    end
                end

                REPORT: begin
                    // First REPORT clock loads the result; ack is only
                    // honoured once dataReady is already up.
                    if (!dataReady) begin
                        foundRow  <= 32'(row);
                        foundCol  <= 32'(col);
                        keyCode   <= 4'(row) * 4'd3 + 4'(col);
                        dataReady <= 1'b1;
                    end else if (ack) begin
                        dataReady <= 1'b0;
                        count     <= '0;
                        state     <= RELEASE;
                    end
                end

                RELEASE: begin
                    if (scol == '1) begin
                        if (count == DEBOUNCE_LAST) begin
                            count <= '0;
                            state <= IDLE;
                            rows  <= '1;
                            busy  <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else begin
                        count <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                    rows  <= '1;
                    busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: self-checking bench for keypad_scan_ctrl with a
// behavioural keypad matrix (pressed keys pull columns low on driven rows).
module tb_keypad_scan_ctrl;

    localparam int S = 4;
    localparam int D = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic [2:0]  cols;
    logic [3:0]  rows;
    logic [31:0] foundRow;
    logic [31:0] foundCol;
    logic [3:0]  keyCode;
    logic        dataReady;
    logic        busy;

    logic [2:0]  key_mask [4];
    logic        ovr_en = 1'b1;
    logic [2:0]  ovr_val = 3'b000;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         row;
        logic [2:0] mask;
        int         exp_row;
        int         exp_col;
        int         exp_code;
        int         exp_edge;
    } vec_t;

    typedef struct {
        int row;
        int col;
        int code;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[5];

    keypad_scan_ctrl #(
        .SETTLE_CYCLES   (S),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (16)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .ack       (ack),
        .cols      (cols),
        .rows      (rows),
        .foundRow  (foundRow),
        .foundCol  (foundCol),
        .keyCode   (keyCode),
        .dataReady (dataReady),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    always_comb begin
        logic [2:0] pulled;
        pulled = '0;
        for (int r = 0; r < 4; r++)
            if (!rows[r]) pulled = pulled | key_mask[r];
        cols = ovr_en ? ovr_val : ~pulled;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Caller has just passed edge 0; returns the edge index after which
    // dataReady was first seen high, or -1 on timeout.
    task automatic wait_report(input int budget, output int edges);
        edges = -1;
        for (int n = 1; n <= budget; n++) begin
            tick();
            if (dataReady) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_foundRow"}, foundRow, e.row);
            check({tag, "_foundCol"}, foundCol, e.col);
            check({tag, "_keyCode"}, keyCode, e.code);
        end
    endtask

    task automatic ack_and_release(input string tag, input int row, input int exp_edges);
        int n;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_ack_drop"}, dataReady, 0);
        key_mask[row] = '0;
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (!busy) begin
                n = i;
                break;
            end
        end
        if (exp_edges > 0)
            check({tag, "_release_edges"}, n, exp_edges);
        else
            check({tag, "_release_done"}, (n > 0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int e;
        int bad;
        int seen;

        for (int r = 0; r < 4; r++) key_mask[r] = '0;

        vecs[0] = '{2, 3'b010, 2, 1, 7,  3*S + D + 1};
        vecs[1] = '{3, 3'b101, 3, 0, 9,  4*S + D + 1};
        vecs[2] = '{0, 3'b100, 0, 2, 2,  1*S + D + 1};
        vecs[3] = '{1, 3'b001, 1, 0, 3,  2*S + D + 1};
        vecs[4] = '{3, 3'b100, 3, 2, 11, 4*S + D + 1};

        // Reset with all columns pulled low.
        repeat (3) tick();
        check("rst_rows", rows, 4'b1111);
        check("rst_dataReady", dataReady, 0);
        check("rst_busy", busy, 0);
        check("rst_foundRow", foundRow, 0);
        check("rst_foundCol", foundCol, 0);
        check("rst_keyCode", keyCode, 0);
        #2;
        ovr_en = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();

        foreach (vecs[k]) begin
            key_mask[vecs[k].row] = vecs[k].mask;
            sb.push_back('{vecs[k].exp_row, vecs[k].exp_col, vecs[k].exp_code});
            pulse_start();
            wait_report(200, e);
            check($sformatf("v%0d_latency", k), e, vecs[k].exp_edge);
            pop_compare($sformatf("v%0d", k));

            // Without ack the report must stay put.
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (dataReady !== 1'b1 || foundRow !== 32'(vecs[k].exp_row) ||
                    foundCol !== 32'(vecs[k].exp_col) || keyCode !== 4'(vecs[k].exp_code))
                    bad++;
            end
            check($sformatf("v%0d_hold", k), bad, 0);

            ack = 1'b1;
            tick();
            ack = 1'b0;
            check($sformatf("v%0d_ack_drop", k), dataReady, 0);

            // Key still held: stays busy, and start is ignored.
            bad = 0;
            start = 1'b1;
            for (int i = 0; i < 6; i++) begin
                tick();
                start = 1'b0;
                if (!busy) bad++;
            end
            check($sformatf("v%0d_busy_held", k), bad, 0);

            key_mask[vecs[k].row] = '0;
            e = -1;
            for (int i = 1; i <= 40; i++) begin
                tick();
                if (!busy) begin
                    e = i;
                    break;
                end
            end
            check($sformatf("v%0d_release_edges", k), e, D + 2);
            check($sformatf("v%0d_idle_rows", k), rows, 4'b1111);
            bad = 0;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (busy) bad++;
            end
            check($sformatf("v%0d_start_ignored", k), bad, 0);
        end

        // Asynchronous reset in the middle of DEBOUNCE on row 1.
        key_mask[1] = 3'b100;
        pulse_start();
        repeat (10) tick();
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_rows", rows, 4'b1111);
        check("midrst_busy", busy, 0);
        check("midrst_dataReady", dataReady, 0);
        check("midrst_keyCode", keyCode, 0);
        #2;
        reset_n = 1'b1;
        tick();
        sb.push_back('{1, 2, 5});
        pulse_start();
        wait_report(200, e);
        check("midrst_rescan_latency", e, 2*S + D + 1);
        pop_compare("midrst");
        ack_and_release("midrst", 1, D + 2);

        // Bouncing key on row 0 col 0, then held steady.
        tick();
        sb.push_back('{0, 0, 0});
        pulse_start();
        seen = 0;
        for (int i = 0; i < 36; i++) begin
            if (i % 3 == 0) key_mask[0] = key_mask[0] ^ 3'b001;
            tick();
            if (dataReady) seen++;
        end
        check("bounce_no_report", seen, 0);
        key_mask[0] = 3'b001;
        wait_report(300, e);
        check("bounce_min_latency", (e >= D + 3), 1);
        pop_compare("bounce");
        ack_and_release("bounce", 0, 0);

        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
